// File: rtl/maskable_adder_mask_ctrl.sv
// Drives operand pairs onto a maskable carry adder and reports each approximate sum with its absolute error.
// Once per window it moves the mask level against an error threshold. Optional MASK_STATS_EN adds statistics outputs.
module maskable_adder_mask_ctrl #(
    parameter int W       = 4,
    parameter int ADD_LAT = 1,
    parameter int WIN_W   = 4,
    parameter int ACC_W   = 12,
    localparam int LVL_W  = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    output logic [W-1:0]     add_mask,
    input  logic [W:0]       add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       out_sum,
    output logic [W:0]       out_err,
    input  logic [ACC_W-1:0] cfg_threshold,
    input  logic [WIN_W-1:0] cfg_window,
`ifdef MASK_STATS_EN
    output logic [15:0]      stat_ops,
    output logic [W:0]       stat_err_max,
    output logic [7:0]       stat_adapt_dn,
`endif
    output logic [LVL_W-1:0] mask_level
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ADAPT} state_t;

    localparam logic [2:0]       LAT_INIT = 3'(ADD_LAT);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(W);

    state_t           state_q, state_d;
    logic [W-1:0]     add_a_q, add_a_d, add_b_q, add_b_d;
    logic [W-1:0]     mask_q, mask_d;
    logic [2:0]       lat_q, lat_d;
    logic             out_valid_q, out_valid_d;
    logic [W:0]       out_sum_q, out_sum_d, out_err_q, out_err_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIN_W-1:0] win_q, win_d;

    logic [W:0]       exact;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_sat;

    function automatic logic [W-1:0] mask_of(input logic [LVL_W-1:0] lvl);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) begin
            m[i] = (LVL_W'(i) >= lvl);
        end
        return m;
    endfunction

    assign exact   = {1'b0, add_a_q} + {1'b0, add_b_q};
    assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(out_err_q);
    assign acc_sat = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

    always_comb begin
        state_d     = state_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        mask_d      = mask_q;
        lat_d       = lat_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_err_d   = out_err_q;
        level_d     = level_q;
        acc_d       = acc_q;
        win_d       = win_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    add_a_d = in_a;
                    add_b_d = in_b;
                    lat_d   = LAT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    out_sum_d   = add_sum;
                    out_err_d   = (exact >= add_sum) ? exact - add_sum : add_sum - exact;
                    out_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = acc_sat;
                    if (win_q == cfg_window) begin
                        state_d = ADAPT;
                    end else begin
                        win_d   = win_q + WIN_W'(1);
                        state_d = IDLE;
                    end
                end
            end
            ADAPT: begin
                // Too much error: tighten first; only relax when well under half the budget.
                if (acc_q > cfg_threshold && level_q != '0) begin
                    level_d = level_q - LVL_W'(1);
                end else if (acc_q < (cfg_threshold >> 1) && level_q < LVL_MAX) begin
                    level_d = level_q + LVL_W'(1);
                end
                mask_d  = mask_of(level_d);
                acc_d   = '0;
                win_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            add_a_q     <= '0;
            add_b_q     <= '0;
            mask_q      <= '1;
            lat_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_err_q   <= '0;
            level_q     <= '0;
            acc_q       <= '0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            mask_q      <= mask_d;
            lat_q       <= lat_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_err_q   <= out_err_d;
            level_q     <= level_d;
            acc_q       <= acc_d;
            win_q       <= win_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_mask   = mask_q;
    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;
    assign out_err    = out_err_q;
    assign mask_level = level_q;

`ifdef MASK_STATS_EN
    logic [15:0] ops_q, ops_d;
    logic [W:0]  err_max_q, err_max_d;
    logic [7:0]  dn_q, dn_d;

    always_comb begin
        ops_d     = ops_q;
        err_max_d = err_max_q;
        dn_d      = dn_q;
        if (state_q == RESP && out_ready) begin
            ops_d = ops_q + 16'd1;
            if (out_err_q > err_max_q) begin
                err_max_d = out_err_q;
            end
        end
        if (state_q == ADAPT && level_d < level_q && dn_q != 8'hFF) begin
            dn_d = dn_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q     <= '0;
            err_max_q <= '0;
            dn_q      <= '0;
        end else begin
            ops_q     <= ops_d;
            err_max_q <= err_max_d;
            dn_q      <= dn_d;
        end
    end

    assign stat_ops      = ops_q;
    assign stat_err_max  = err_max_q;
    assign stat_adapt_dn = dn_q;
`endif

endmodule

// File: tb/tb_maskable_adder_mask_ctrl.sv
// Scoreboard bench: a behavioural window/threshold model predicts each result and the mask in force for it.
module tb_maskable_adder_mask_ctrl;
    localparam int W = 4, ADD_LAT = 1, WIN_W = 4, ACC_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [W-1:0]     in_a, in_b, add_a, add_b, add_mask;
    logic [W:0]       add_sum, out_sum, out_err;
    logic             out_valid, out_ready;
    logic [ACC_W-1:0] cfg_threshold;
    logic [WIN_W-1:0] cfg_window;
    logic [2:0]       mask_level;
    logic [W:0]       delta_cur;
`ifdef MASK_STATS_EN
    logic [15:0]      stat_ops;
    logic [W:0]       stat_err_max;
    logic [7:0]       stat_adapt_dn;
`endif

    maskable_adder_mask_ctrl #(.W(W), .ADD_LAT(ADD_LAT), .WIN_W(WIN_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_mask(add_mask),
        .add_sum(add_sum), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_err(out_err),
        .cfg_threshold(cfg_threshold), .cfg_window(cfg_window),
`ifdef MASK_STATS_EN
        .stat_ops(stat_ops), .stat_err_max(stat_err_max), .stat_adapt_dn(stat_adapt_dn),
`endif
        .mask_level(mask_level)
    );

    always #5 clk = ~clk;

    // Adder stand-in: exact sum minus a per-operation error chosen by the stimulus.
    always_comb add_sum = {1'b0, add_a} + {1'b0, add_b} - delta_cur;

    typedef struct {int sum; int err; int lvl;} exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    int m_lvl, m_acc, m_n, m_ops, m_errmax, m_dn;
    bit hold_rdy = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int mask_for(input int lvl);
        return ((1 << W) - 1) - ((1 << lvl) - 1);
    endfunction

    task automatic model_reset();
        m_lvl = 0; m_acc = 0; m_n = 0; m_ops = 0; m_errmax = 0; m_dn = 0;
        sb.delete();
    endtask

    // One result: accumulate, and at the end of a window move the level.
    task automatic model_op(input int a, input int b, input int d);
        exp_t e;
        e.sum = a + b - d;
        e.err = d;
        e.lvl = m_lvl;
        sb.push_back(e);
        m_ops++;
        if (d > m_errmax) m_errmax = d;
        m_acc = (m_acc + d > 4095) ? 4095 : m_acc + d;
        if (m_n == int'(cfg_window)) begin
            if (m_acc > int'(cfg_threshold) && m_lvl > 0) begin
                m_lvl--; m_dn++;
            end else if (m_acc < int'(cfg_threshold) / 2 && m_lvl < W) begin
                m_lvl++;
            end
            m_acc = 0;
            m_n = 0;
        end else begin
            m_n = (m_n + 1) % 16;
        end
    endtask

    task automatic issue(input int a, input int b, input int d);
        int n = 0;
        if (d > a + b) d = a + b;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("issue_timeout", 0, 1);
        in_a = W'(a); in_b = W'(b); delta_cur = (W+1)'(d); in_valid = 1'b1;
        model_op(a, b, d);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (sb.size() != 0 || !in_ready) chk("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Downstream readiness, randomised unless the bench is holding it off.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every out handshake pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_sum", int'(out_sum), e.sum);
                    chk("out_err", int'(out_err), e.err);
                    chk("mask_level", int'(mask_level), e.lvl);
                    chk("add_mask", int'(add_mask), mask_for(e.lvl));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; delta_cur = '0;
        cfg_threshold = 12'd2; cfg_window = 4'd3;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_add_mask", int'(add_mask), 15);
        chk("rst_mask_level", int'(mask_level), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_add_a", int'(add_a), 0);
        @(posedge clk); #1 rst = 1'b0;

        // 3+5 through an exact adder, then hold out_ready low for 5 cycles.
        issue(3, 5, 0);
        @(negedge clk); chk("lat_valid_early", int'(out_valid), 0);
        @(negedge clk); chk("lat_valid_on", int'(out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_sum", int'(out_sum), 8);
            chk("stall_err", int'(out_err), 0);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        hold_rdy = 1'b0;

        // Error window at level 0 clamps; two clean windows relax to 2; an error window tightens to 1.
        for (int i = 0; i < 3; i++) issue($urandom_range(1, 7), $urandom_range(0, 7), 1);
        drain(); chk("clamp_level0", int'(mask_level), 0);
        cfg_threshold = 12'd4;
        for (int i = 0; i < 8; i++) issue($urandom_range(0, 15), $urandom_range(0, 15), 0);
        drain(); chk("relax_level2", int'(mask_level), 2);
        chk("relax_mask", int'(add_mask), 12);
        cfg_threshold = 12'd2;
        for (int i = 0; i < 4; i++) issue($urandom_range(1, 15), $urandom_range(0, 15), 1);
        drain(); chk("tighten_level1", int'(mask_level), 1);
        chk("tighten_mask", int'(add_mask), 14);

        // 16-op exact windows climb to full approximation and stay there.
        do_reset();
        cfg_threshold = 12'd4; cfg_window = 4'd15;
        for (int i = 0; i < 96; i++) issue($urandom_range(0, 15), $urandom_range(0, 15), 0);
        drain(); chk("top_level4", int'(mask_level), 4);
        chk("top_mask", int'(add_mask), 0);

        // Reset while an operation is in WAIT at level 3.
        do_reset();
        cfg_window = 4'd0;
        for (int i = 0; i < 3; i++) issue($urandom_range(0, 15), $urandom_range(0, 15), 0);
        drain(); chk("pre_rst_level3", int'(mask_level), 3);
        issue(6, 7, 0);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_add_mask", int'(add_mask), 15);
        chk("midrst_level", int'(mask_level), 0);
        @(posedge clk); #1 rst = 1'b0;
        model_reset();

        // 20 ops with error pattern 0,1,3,2.
        cfg_threshold = 12'd4095; cfg_window = 4'd3;
        for (int i = 0; i < 20; i++) begin
            int pat [4] = '{0, 1, 3, 2};
            issue(7, 7, pat[i % 4]);
        end
        drain();
`ifdef MASK_STATS_EN
        chk("stat_ops20", int'(stat_ops), 20);
        chk("stat_err_max3", int'(stat_err_max), 3);
`endif

        // Random traffic with configuration changes between windows.
        for (int blk = 0; blk < 30; blk++) begin
            cfg_threshold = ACC_W'($urandom_range(0, 20));
            cfg_window    = WIN_W'($urandom_range(0, 5));
            for (int i = 0; i <= int'(cfg_window); i++)
                issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
            drain();
            chk("rand_level", int'(mask_level), m_lvl);
        end
`ifdef MASK_STATS_EN
        chk("stat_ops", int'(stat_ops), m_ops);
        chk("stat_err_max", int'(stat_err_max), m_errmax);
        chk("stat_adapt_dn", int'(stat_adapt_dn), m_dn);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
